pcpi_issue_ctrl: RTL and testbench



---
 rtl/pcpi_pkg.sv | 20 ++
 rtl/pcpi_resp_select.sv | 31 +++
 rtl/pcpi_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_pcpi_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
// Shared types for the PCPI issue/collect stage: FSM states, MUL/DIV decode
// constants and the response record returned to the core.
package pcpi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
        logic        trap;
    } resp_t;

endpackage

// File: rtl/pcpi_resp_select.sv
// Priority select of result/status across N co-processors; index 0 has the
// highest priority (the multiplier sits there).
module pcpi_resp_select #(
    parameter int N = 2
) (
    input  logic [N-1:0]       cp_wr,
    input  logic [N-1:0]       cp_ready,
    input  logic [N-1:0]       cp_wait,
    input  logic [N-1:0][31:0] cp_rd,
    output logic               any_ready,
    output logic               any_wait,
    output logic               sel_wr,
    output logic [31:0]        sel_rd
);

    // Walk from lowest priority up so the last hit (lowest index) wins.
    always_comb begin
        sel_wr = 1'b0;
        sel_rd = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cp_ready[i]) begin
                sel_wr = cp_wr[i];
                sel_rd = cp_rd[i];
            end
        end
    end

    assign any_ready = |cp_ready;
    assign any_wait  = |cp_wait;

endmodule

// File: rtl/pcpi_issue_ctrl.sv
// Core-side PCPI issue/collect: broadcasts one request to the co-processors,
// collects the first ready result, or traps if nobody claims it in time.
//
// state | meaning
// IDLE  | waiting for a core request; req_ready high
// ISSUE | pcpi_valid high, watching wait/ready, timeout counting
// RESP  | response held for the core until resp_accept
module pcpi_issue_ctrl
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit ENABLE_DIV     = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_wr,
    output logic [31:0] resp_rd,
    output logic        resp_trap,
    input  logic        resp_accept,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        mul_wr,
    input  logic        mul_wait,
    input  logic        mul_ready,
    input  logic [31:0] mul_rd,
    input  logic        div_wr,
    input  logic        div_wait,
    input  logic        div_ready,
    input  logic [31:0] div_rd
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    resp_t         resp_q, resp_nxt;
    logic          resp_valid_nxt, pcpi_valid_nxt;
    logic [31:0]   insn_nxt, rs1_nxt, rs2_nxt;

    logic          any_ready, any_wait, sel_wr;
    logic [31:0]   sel_rd;

    pcpi_resp_select #(.N(2)) u_sel (
        .cp_wr     ({div_wr    & ENABLE_DIV, mul_wr}),
        .cp_ready  ({div_ready & ENABLE_DIV, mul_ready}),
        .cp_wait   ({div_wait  & ENABLE_DIV, mul_wait}),
        .cp_rd     ({div_rd & {32{ENABLE_DIV}}, mul_rd}),
        .any_ready (any_ready),
        .any_wait  (any_wait),
        .sel_wr    (sel_wr),
        .sel_rd    (sel_rd)
    );

    assign req_ready  = (state == IDLE) && resetn;
    assign resp_wr    = resp_q.wr;
    assign resp_rd    = resp_q.rd;
    assign resp_trap  = resp_q.trap;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        resp_nxt       = resp_q;
        resp_valid_nxt = resp_valid;
        pcpi_valid_nxt = pcpi_valid;
        insn_nxt       = pcpi_insn;
        rs1_nxt        = pcpi_rs1;
        rs2_nxt        = pcpi_rs2;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    insn_nxt       = req_insn;
                    rs1_nxt        = req_rs1;
                    rs2_nxt        = req_rs2;
                    pcpi_valid_nxt = 1'b1;
                    cnt_nxt        = '0;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                // Ready beats both wait and an expiring counter.
                if (any_ready) begin
                    resp_nxt       = '{wr: sel_wr, rd: sel_rd, trap: 1'b0};
                    pcpi_valid_nxt = 1'b0;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = RESP;
                end else if (any_wait) begin
                    cnt_nxt = '0;
                end else if (cnt >= CNT_LAST) begin
                    resp_nxt       = '{wr: 1'b0, rd: 32'd0, trap: 1'b1};
                    pcpi_valid_nxt = 1'b0;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                if (resp_accept) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_q     <= '0;
            resp_valid <= 1'b0;
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            resp_q     <= resp_nxt;
            resp_valid <= resp_valid_nxt;
            pcpi_valid <= pcpi_valid_nxt;
            pcpi_insn  <= insn_nxt;
            pcpi_rs1   <= rs1_nxt;
            pcpi_rs2   <= rs2_nxt;
        end
    end

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Bench for pcpi_issue_ctrl with a behavioural fast multiplier attached and
// a directly driven divider; responses are checked against a queue.
module tb_pcpi_issue_ctrl;
    import pcpi_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_insn = '0, req_rs1 = '0, req_rs2 = '0;
    logic        req_ready;
    logic        resp_valid, resp_wr, resp_trap;
    logic [31:0] resp_rd;
    logic        resp_accept = 1'b0;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        mul_wr, mul_wait, mul_ready;
    logic [31:0] mul_rd;
    logic        div_wr = 1'b0, div_wait = 1'b0, div_ready = 1'b0;
    logic [31:0] div_rd = '0;
    logic        f_mul_ready = 1'b0;
    logic [31:0] f_mul_rd = '0;

    int n_chk = 0;
    int n_bad = 0;
    resp_t sb[$];

    always #5 clk = ~clk;

    pcpi_issue_ctrl #(.TIMEOUT_CYCLES(16), .ENABLE_DIV(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rd(resp_rd), .resp_trap(resp_trap),
        .resp_accept(resp_accept),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .mul_wr(mul_wr), .mul_wait(mul_wait), .mul_ready(mul_ready), .mul_rd(mul_rd),
        .div_wr(div_wr), .div_wait(div_wait), .div_ready(div_ready), .div_rd(div_rd)
    );

    // Fast multiplier model: ready two cycles after pcpi_valid, busy until valid drops.
    logic        m_busy, m_st, m_ready, m_wait;
    logic [31:0] m_rd, m_res;
    logic [63:0] p_uu, p_ss, p_su;
    wire is_mul = (pcpi_insn[6:0] == OPCODE_OP) && (pcpi_insn[31:25] == FUNCT7_MULDIV)
                  && !pcpi_insn[14];

    always_comb begin
        p_uu = {32'd0, pcpi_rs1} * {32'd0, pcpi_rs2};
        p_ss = $signed({{32{pcpi_rs1[31]}}, pcpi_rs1}) * $signed({{32{pcpi_rs2[31]}}, pcpi_rs2});
        p_su = $signed({{32{pcpi_rs1[31]}}, pcpi_rs1}) * $signed({32'd0, pcpi_rs2});
        m_res = '0;
        case (pcpi_insn[13:12])
            2'd0: m_res = p_uu[31:0];
            2'd1: m_res = p_ss[63:32];
            2'd2: m_res = p_su[63:32];
            default: m_res = p_uu[63:32];
        endcase
    end

    always @(posedge clk) begin
        if (!resetn) begin
            m_busy <= 1'b0; m_st <= 1'b0; m_ready <= 1'b0; m_wait <= 1'b0; m_rd <= '0;
        end else begin
            m_wait  <= pcpi_valid && is_mul;
            m_ready <= 1'b0;
            m_st    <= 1'b0;
            if (!pcpi_valid) m_busy <= 1'b0;
            else if (is_mul && !m_busy) begin
                m_busy <= 1'b1;
                m_st   <= 1'b1;
            end
            if (m_st) begin
                m_ready <= 1'b1;
                m_rd    <= m_res;
            end
        end
    end

    assign mul_ready = m_ready | f_mul_ready;
    assign mul_wr    = mul_ready;
    assign mul_wait  = m_wait;
    assign mul_rd    = m_ready ? m_rd : f_mul_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, OPCODE_OP};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first ISSUE cycle.
    task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_insn = insn; req_rs1 = a; req_rs2 = b;
        chk("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pcpi_valid_rise", pcpi_valid, 1);
        chk("pcpi_insn", pcpi_insn, insn);
    endtask

    task automatic take_resp(input int hold);
        int    n = 0;
        logic  ok = 1'b1;
        resp_t e, snap;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", resp_valid, 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_wr", resp_wr, e.wr);
            chk("resp_rd", resp_rd, e.rd);
            chk("resp_trap", resp_trap, e.trap);
        end
        if (hold > 0) begin
            snap = '{wr: resp_wr, rd: resp_rd, trap: resp_trap};
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!resp_valid || req_ready || resp_wr !== snap.wr || resp_rd !== snap.rd
                    || resp_trap !== snap.trap) ok = 1'b0;
            end
            chk("resp_hold_stable", ok, 1);
        end
        resp_accept = 1'b1;
        @(negedge clk);
        resp_accept = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_pcpi_valid", pcpi_valid, 0);
        chk("rst_pcpi_insn", pcpi_insn, 0);
        chk("rst_pcpi_rs1", pcpi_rs1, 0);
        chk("rst_pcpi_rs2", pcpi_rs2, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_wr", resp_wr, 0);
        chk("rst_resp_rd", resp_rd, 0);
        chk("rst_resp_trap", resp_trap, 0);
        chk("rst_req_ready_low", req_ready, 0);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_rd);
        int n, pv;
        sb.push_back('{wr: 1'b1, rd: exp_rd, trap: 1'b0});
        issue(mk(FUNCT7_MULDIV, 3'b000), a, b);
        n = 1; pv = 0;
        while (!resp_valid && n < 100) begin
            if (pcpi_valid) pv++;
            @(negedge clk);
            n++;
        end
        chk("mul_latency", n, 4);
        chk("mul_pcpi_valid_cycles", pv, 3);
        chk("mul_pcpi_valid_drop", pcpi_valid, 0);
        take_resp(0);
    endtask

    initial begin
        int n, pv;
        repeat (3) @(negedge clk);
        check_reset_vals();
        resetn = 1'b1;
        #1 chk("req_ready_after_reset", req_ready, 1);
        @(negedge clk);

        // Stray readies in IDLE are ignored.
        div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'h9; f_mul_ready = 1'b1;
        @(negedge clk);
        div_ready = 1'b0; div_wr = 1'b0; div_rd = '0; f_mul_ready = 1'b0;
        chk("idle_ready_ignored", resp_valid, 0);
        chk("idle_no_issue", pcpi_valid, 0);

        // MULHU with the response withheld, then a back-to-back MUL 3*7.
        sb.push_back('{wr: 1'b1, rd: 32'hFFFF_FFFE, trap: 1'b0});
        issue(mk(FUNCT7_MULDIV, 3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        take_resp(10);
        run_mul(32'd3, 32'd7, 32'd21);

        // Unclaimed instruction times out into a trap.
        sb.push_back('{wr: 1'b0, rd: 32'd0, trap: 1'b1});
        issue(mk(7'b0100000, 3'b000), 32'd5, 32'd6);
        n = 1; pv = 0;
        while (!resp_valid && n < 100) begin
            if (pcpi_valid) pv++;
            @(negedge clk);
            n++;
        end
        chk("trap_issue_cycles", pv, 16);
        chk("trap_pcpi_valid_drop", pcpi_valid, 0);
        take_resp(0);

        // Long divider wait then ready.
        sb.push_back('{wr: 1'b1, rd: 32'd5, trap: 1'b0});
        issue(mk(FUNCT7_MULDIV, 3'b100), 32'd25, 32'd5);
        div_wait = 1'b1;
        repeat (40) @(negedge clk);
        chk("div_wait_no_resp", resp_valid, 0);
        div_wait = 1'b0; div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'd5;
        @(negedge clk);
        div_ready = 1'b0; div_wr = 1'b0; div_rd = '0;
        take_resp(0);

        // Simultaneous readies: multiplier wins.
        sb.push_back('{wr: 1'b1, rd: 32'd1, trap: 1'b0});
        issue(mk(7'b0100000, 3'b001), 32'd0, 32'd0);
        f_mul_ready = 1'b1; f_mul_rd = 32'd1;
        div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'd2;
        @(negedge clk);
        f_mul_ready = 1'b0; f_mul_rd = '0;
        div_ready = 1'b0; div_wr = 1'b0; div_rd = '0;
        take_resp(0);

        // Reset during ISSUE.
        issue(mk(7'b0100000, 3'b000), 32'd1, 32'd2);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_vals();
        resetn = 1'b1;
        #1 chk("req_ready_after_issue_rst", req_ready, 1);
        @(negedge clk);

        // Reset during RESP discards the pending response.
        issue(mk(7'b0100000, 3'b000), 32'd1, 32'd2);
        div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'hABCD;
        @(negedge clk);
        div_ready = 1'b0; div_wr = 1'b0; div_rd = '0;
        chk("resp_before_rst", resp_valid, 1);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_vals();
        resetn = 1'b1;
        #1 chk("req_ready_after_resp_rst", req_ready, 1);
        @(negedge clk);

        run_mul(32'd12, 32'd12, 32'd144);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

endmodule
